// File: rtl/gcd_pkg.sv
// gcd_pkg: shared definitions for the GCD sequencer and its helpers.
//   - gcd_seq_state_e      : sequencer FSM states
//   - GCD_DATA_WIDTH       : default operand/result width
//   - GCD_CNT_WIDTH        : default iteration counter width
//   - GCD_TIMEOUT_CYCLES   : default WAIT-cycle limit (GCD_SEQ_TIMEOUT_EN builds)
//   - GCD_BLANK_CYCLES     : leading WAIT cycles in which core_valid is ignored
package gcd_pkg;

  localparam int GCD_DATA_WIDTH     = 8;
  localparam int GCD_CNT_WIDTH      = 16;
  localparam int GCD_TIMEOUT_CYCLES = 1024;

  // The core may still show the previous pair's valid during the first
  // WAIT cycle, so that many cycles are masked before a result is trusted.
  localparam int GCD_BLANK_CYCLES   = 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    DONE
  } gcd_seq_state_e;

endpackage

// File: rtl/gcd_seq_out_reg.sv
// gcd_seq_out_reg: single-entry valid/ready holding register.
//   clk, reset  : clock, asynchronous active-high reset
//   load        : capture load_data and raise valid on this edge
//   load_data   : payload to capture
//   ready       : downstream accepts the held payload
//   valid, data : held payload and its valid flag
// A load wins over a simultaneous drain so no result is ever lost.
module gcd_seq_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Payload stays stable while valid is high; it only changes on a load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/gcd_sequencer.sv
// gcd_sequencer: initiator-side controller for the enable/valid GCD core.
//   clk, reset            : clock, asynchronous active-high reset
//   in_valid/in_ready     : upstream operand stream, operands in_a/in_b
//   core_enable           : one-cycle start pulse to the core
//   core_a/core_b         : registered operands, stable from START to DONE
//   core_valid/core_y     : core result (level valid, held until next enable)
//   out_valid/out_ready   : downstream result stream
//   out_y                 : captured GCD
//   out_cycles            : WAIT edges until capture, saturating
//   out_err               : timeout flag
// Optional feature macro: GCD_SEQ_TIMEOUT_EN. When defined, a WAIT lasting
// TIMEOUT_CYCLES edges without core_valid completes with out_err = 1 and
// out_y = 0. When undefined, WAIT lasts indefinitely and out_err is tied 0.
module gcd_sequencer
  import gcd_pkg::*;
#(
  parameter int DATA_WIDTH     = GCD_DATA_WIDTH,
  parameter int CNT_WIDTH      = GCD_CNT_WIDTH,
  parameter int TIMEOUT_CYCLES = GCD_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  core_enable,
  output logic [DATA_WIDTH-1:0] core_a,
  output logic [DATA_WIDTH-1:0] core_b,
  input  logic                  core_valid,
  input  logic [DATA_WIDTH-1:0] core_y,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_y,
  output logic [CNT_WIDTH-1:0]  out_cycles,
  output logic                  out_err
);

  gcd_seq_state_e        state;
  logic [CNT_WIDTH-1:0]  count;
  logic [CNT_WIDTH-1:0]  count_next;
  logic                  blanked;
  logic                  valid_hit;
  logic                  capture;
  logic                  accept;
  logic [DATA_WIDTH-1:0] cap_y;

  // count_next doubles as the reported cycle count: it includes the
  // capture edge itself and saturates at all-ones.
  assign count_next = (&count) ? count : count + CNT_WIDTH'(1);
  assign blanked    = (count < CNT_WIDTH'(GCD_BLANK_CYCLES));
  assign valid_hit  = (state == WAIT) && !blanked && core_valid;

  // A new pair is taken only in IDLE, and only if the result slot is free
  // or is being drained on this same edge.
  assign in_ready = !reset && (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

`ifdef GCD_SEQ_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam int PAY_W = DATA_WIDTH + CNT_WIDTH + 1;

  logic             timeout_hit;
  logic [PAY_W-1:0] cap_payload;
  logic [PAY_W-1:0] held_payload;

  // A genuine result on the limit edge takes priority over the timeout.
  assign timeout_hit = (state == WAIT) && !valid_hit && (count_next == TIMEOUT_LIMIT);
  assign capture     = valid_hit || timeout_hit;
  assign cap_y       = valid_hit ? core_y : '0;
  assign cap_payload = {timeout_hit, count_next, cap_y};
  assign {out_err, out_cycles, out_y} = held_payload;
`else
  localparam int PAY_W = DATA_WIDTH + CNT_WIDTH;

  logic [PAY_W-1:0] cap_payload;
  logic [PAY_W-1:0] held_payload;

  assign capture     = valid_hit;
  assign cap_y       = core_y;
  assign cap_payload = {count_next, cap_y};
  assign {out_cycles, out_y} = held_payload;
  assign out_err     = 1'b0;
`endif

  // Sequencer FSM. core_enable is registered: it rises on the acceptance
  // edge and falls on the START->WAIT edge, giving exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      core_enable <= 1'b0;
      core_a      <= '0;
      core_b      <= '0;
      count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            core_a      <= in_a;
            core_b      <= in_b;
            core_enable <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          core_enable <= 1'b0;
          count       <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          count <= count_next;
          if (capture) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  gcd_seq_out_reg #(
    .WIDTH(PAY_W)
  ) u_out_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (capture),
    .load_data(cap_payload),
    .ready    (out_ready),
    .valid    (out_valid),
    .data     (held_payload)
  );

endmodule

// File: tb/tb_gcd_sequencer.sv
// tb_gcd_sequencer: bench for gcd_sequencer with a behavioural GCD core.
// The core model answers core_lat edges after it samples core_enable; in
// "stale" mode it keeps the previous valid/result high for one extra edge.
// Build with GCD_SEQ_TIMEOUT_EN defined to include the timeout sequence.
module tb_gcd_sequencer;

  localparam int TB_TIMEOUT = 16;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        core_enable;
  logic [7:0]  core_a;
  logic [7:0]  core_b;
  logic        core_valid;
  logic [7:0]  core_y;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_y;
  logic [15:0] out_cycles;
  logic        out_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int en_pulses = 0;
  int accept_cyc = 0;

  int   core_lat   = 1;
  bit   core_stale = 0;
  int   core_cd;
  bit   core_busy;
  bit   core_clr;
  logic [7:0] core_pend;

  gcd_sequencer #(
    .DATA_WIDTH    (8),
    .CNT_WIDTH     (16),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .core_enable(core_enable),
    .core_a     (core_a),
    .core_b     (core_b),
    .core_valid (core_valid),
    .core_y     (core_y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_cycles (out_cycles),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (core_enable) en_pulses <= en_pulses + 1;

  // Euclid by repeated remainder; gcd(x,0) = x, gcd(0,0) = 0.
  function automatic logic [7:0] gcd_ref(input logic [7:0] a, input logic [7:0] b);
    int x = a;
    int y = b;
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return 8'(x);
  endfunction

  // Behavioural core with synchronous reset and level valid.
  always @(posedge clk) begin
    if (reset) begin
      core_valid <= 1'b0;
      core_y     <= 8'd0;
      core_busy  <= 1'b0;
      core_clr   <= 1'b0;
      core_cd    <= 0;
      core_pend  <= 8'd0;
    end else if (core_enable) begin
      core_pend <= gcd_ref(core_a, core_b);
      core_cd   <= core_lat;
      core_busy <= (core_lat != 0);
      if (core_stale) core_clr <= 1'b1;
      else            core_valid <= 1'b0;
    end else begin
      if (core_clr) begin
        core_valid <= 1'b0;
        core_clr   <= 1'b0;
      end
      if (core_busy) begin
        if (core_cd == 1) begin
          core_valid <= 1'b1;
          core_y     <= core_pend;
          core_busy  <= 1'b0;
        end else begin
          core_cd <= core_cd - 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input int lat, input bit stale);
    int guard = 0;
    core_lat   = lat;
    core_stale = stale;
    @(negedge clk);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    while (!in_ready && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("accept_ready", in_ready, 1);
    @(posedge clk);
    #1 accept_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Result latency from acceptance is one START edge plus the WAIT edges.
  task automatic waitResult(input string name, input logic [7:0] exp_y,
                            input int exp_cycles, input logic exp_err);
    int guard = 0;
    while (!out_valid && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({name, "_valid"},   out_valid, 1);
    checkOutput({name, "_latency"}, cyc - accept_cyc, exp_cycles + 1);
    checkOutput({name, "_y"},       out_y, exp_y);
    checkOutput({name, "_cycles"},  out_cycles, exp_cycles);
    checkOutput({name, "_err"},     out_err, exp_err);
  endtask

  task automatic runPair(input string name, input logic [7:0] a, input logic [7:0] b,
                         input int lat, input bit stale, input int hold,
                         input logic [7:0] exp_y, input int exp_cycles);
    int p0;
    bit stable = 1'b1;
    p0 = en_pulses;
    out_ready = (hold == 0);
    applyStimulus(a, b, lat, stale);
    waitResult(name, exp_y, exp_cycles, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!out_valid || out_y !== exp_y || out_cycles !== 16'(exp_cycles) || in_ready)
        stable = 1'b0;
    end
    if (hold > 0) checkOutput({name, "_hold"}, stable, 1);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput({name, "_drop"}, out_valid, 0);
    checkOutput({name, "_enables"}, en_pulses - p0, 1);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         lat;
    bit         stale;
    logic [7:0] exp_y;
    int         exp_cycles;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   p0;
    bit   ok;
    logic [7:0] ra;
    logic [7:0] rb;
    int   rl;
    bit   rs;

    vecs[0] = '{8'd48,  8'd18,  3, 1'b0, 8'd6,   4};
    vecs[1] = '{8'd0,   8'd0,   1, 1'b0, 8'd0,   2};
    vecs[2] = '{8'd0,   8'd9,   2, 1'b0, 8'd9,   3};
    vecs[3] = '{8'd9,   8'd0,   1, 1'b0, 8'd9,   2};
    vecs[4] = '{8'd255, 8'd255, 5, 1'b0, 8'd255, 6};
    vecs[5] = '{8'd7,   8'd7,   1, 1'b0, 8'd7,   2};
    vecs[6] = '{8'd9,   8'd6,   2, 1'b1, 8'd3,   3};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = 8'd0;
    in_b      = 8'd0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready",    in_ready, 0);
    checkOutput("reset_out_valid",   out_valid, 0);
    checkOutput("reset_core_enable", core_enable, 0);
    checkOutput("reset_out_y",       out_y, 0);
    checkOutput("reset_out_cycles",  out_cycles, 0);
    checkOutput("reset_out_err",     out_err, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_in_ready", in_ready, 1);

    // Directed table, including zero operands and the stale-valid pair.
    for (int i = 0; i < 7; i++)
      runPair($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].lat,
              vecs[i].stale, 0, vecs[i].exp_y, vecs[i].exp_cycles);

    // (255,1) held 20 cycles while (12,8) waits; drain and accept share an edge.
    p0 = en_pulses;
    out_ready = 1'b0;
    applyStimulus(8'd255, 8'd1, 2, 1'b0);
    waitResult("hold_first", 8'd1, 3, 1'b0);
    in_a = 8'd12;
    in_b = 8'd8;
    in_valid = 1'b1;
    core_lat = 3;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!out_valid || out_y !== 8'd1 || out_cycles !== 16'd3 || in_ready) ok = 1'b0;
    end
    checkOutput("hold_stable", ok, 1);
    out_ready = 1'b1;
    #1 checkOutput("hold_ready_on_drain", in_ready, 1);
    @(posedge clk);
    #1 accept_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("hold_drained", out_valid, 0);
    waitResult("hold_second", 8'd4, 4, 1'b0);
    @(negedge clk);
    checkOutput("hold_enables", en_pulses - p0, 2);

    // Reset in the middle of WAIT discards the pending result.
    applyStimulus(8'd200, 8'd3, 10, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("mid_reset_in_ready", in_ready, 0);
    checkOutput("mid_reset_core_a",   core_a, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mid_reset_after_in_ready",  in_ready, 1);
    checkOutput("mid_reset_after_out_valid", out_valid, 0);
    ok = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) ok = 1'b0;
    end
    checkOutput("mid_reset_no_result", ok, 1);
    runPair("after_reset", 8'd10, 8'd4, 2, 1'b0, 0, 8'd2, 3);

`ifdef GCD_SEQ_TIMEOUT_EN
    out_ready = 1'b1;
    applyStimulus(8'd255, 8'd1, 0, 1'b0);
    waitResult("timeout", 8'd0, TB_TIMEOUT, 1'b1);
    @(negedge clk);
    checkOutput("timeout_drop", out_valid, 0);
    runPair("after_timeout", 8'd6, 8'd4, 1, 1'b0, 0, 8'd2, 2);
`endif

    // Randomised pairs against the arithmetic reference.
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rl = $urandom_range(1, 6);
      rs = (rl >= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      runPair($sformatf("rand%0d", i), ra, rb, rl, rs, $urandom_range(0, 3),
              gcd_ref(ra, rb), rl + 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
